// File: rtl/uio_serial_tx_pkg.sv
// Shared types and constants for the uio serial transmitter.
// Optional feature macro: UIO_SERIAL_TX_PARITY_EN (adds an even-parity bit).
package uio_serial_tx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
`ifdef UIO_SERIAL_TX_PARITY_EN
    ST_PARITY = 3'd3,
`endif
    ST_STOP   = 3'd4
  } tx_state_e;

  localparam int         TX_LINE_BIT  = 0;
  localparam int         TX_FRAME_BIT = 1;
  localparam logic [7:0] UIO_OE_MASK  = 8'h03;
  localparam logic       LINE_IDLE    = 1'b1;

endpackage

// File: rtl/uio_serial_tx_baud.sv
// Bit-period down-counter: counts CLKS_PER_BIT-1 to 0, reloads on each
// bit boundary, and is force-loaded when a new frame is accepted.
module uio_serial_tx_baud #(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  output logic bit_tick
);

  localparam logic [7:0] RELOAD = 8'(CLKS_PER_BIT - 1);

  logic [7:0] cnt_q;

  // Count down one bit period; a load or terminal count restarts the period.
  always_ff @(posedge clk) begin
    if (rst || load) begin
      cnt_q <= RELOAD;
    end else if (cnt_q == 8'd0) begin
      cnt_q <= RELOAD;
    end else begin
      cnt_q <= cnt_q - 8'd1;
    end
  end

  assign bit_tick = (cnt_q == 8'd0);

endmodule

// File: rtl/uio_serial_tx.sv
// Byte-wide serial transmitter onto the uio pin bank: start bit, 8 data bits
// LSB first, optional even parity, stop bit. uio[0] is the line, uio[1] the
// frame indicator. Optional feature macro: UIO_SERIAL_TX_PARITY_EN.
module uio_serial_tx
  import uio_serial_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       busy,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  tx_state_e  state_q, state_d;
  logic [7:0] shift_q, shift_d;
  logic [2:0] idx_q, idx_d;
  logic       par_q, par_d;
  logic       baud_load, bit_tick;
  logic       line_d, frame_d, ready_d;
  logic       line_q, frame_q, ready_q;

  uio_serial_tx_baud #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk      (clk),
    .rst      (rst),
    .load     (baud_load),
    .bit_tick (bit_tick)
  );

  // State and bit-index registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      idx_q   <= 3'd0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  // Captured word and its parity; only meaningful while a frame is in flight.
  always_ff @(posedge clk) begin
    shift_q <= shift_d;
    par_q   <= par_d;
  end

  // Next-state logic: advance one bit per baud tick, accept only in IDLE.
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    idx_d     = idx_q;
    par_d     = par_q;
    baud_load = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (tx_valid) begin
          state_d   = ST_START;
          shift_d   = tx_data;
          par_d     = ^tx_data;
          baud_load = 1'b1;
        end
      end
      ST_START: begin
        if (bit_tick) begin
          state_d = ST_DATA;
          idx_d   = 3'd0;
        end
      end
      ST_DATA: begin
        if (bit_tick) begin
          shift_d = shift_q >> 1;
          if (idx_q == 3'd7) begin
`ifdef UIO_SERIAL_TX_PARITY_EN
            state_d = ST_PARITY;
`else
            state_d = ST_STOP;
`endif
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end
      end
`ifdef UIO_SERIAL_TX_PARITY_EN
      ST_PARITY: begin
        if (bit_tick) begin
          state_d = ST_STOP;
        end
      end
`endif
      ST_STOP: begin
        if (bit_tick) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Output decode from the upcoming state so the pins can be registered.
  always_comb begin
    line_d  = LINE_IDLE;
    frame_d = 1'b1;
    ready_d = 1'b0;
    case (state_d)
      ST_IDLE: begin
        frame_d = 1'b0;
        ready_d = 1'b1;
      end
      ST_START:  line_d = 1'b0;
      ST_DATA:   line_d = shift_d[0];
`ifdef UIO_SERIAL_TX_PARITY_EN
      ST_PARITY: line_d = par_d;
`endif
      default:   line_d = LINE_IDLE;
    endcase
  end

  // Registered pin and handshake outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      line_q  <= LINE_IDLE;
      frame_q <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      line_q  <= line_d;
      frame_q <= frame_d;
      ready_q <= ready_d;
    end
  end

  // Pack the pin bank; only the line and frame pins are ever driven.
  always_comb begin
    uio_out               = 8'h00;
    uio_out[TX_LINE_BIT]  = line_q;
    uio_out[TX_FRAME_BIT] = frame_q;
  end

  assign uio_oe   = UIO_OE_MASK;
  assign tx_ready = ready_q;
  assign busy     = frame_q;

endmodule

// File: tb/tb_uio_serial_tx.sv
// Directed bench for uio_serial_tx with a queue-based scoreboard of sent words.
module tb_uio_serial_tx;

  localparam int C  = 4;
`ifdef UIO_SERIAL_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  localparam int F  = NB * C;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] tx_data;
  logic       tx_valid, tx_ready, busy;
  logic [7:0] uio_out, uio_oe;
  logic       tx_valid1, tx_ready1, busy1;
  logic [7:0] uio_out1, uio_oe1;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;

  uio_serial_tx #(.CLKS_PER_BIT(C)) dut (
    .clk(clk), .rst(rst), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .busy(busy), .uio_out(uio_out), .uio_oe(uio_oe)
  );

  uio_serial_tx #(.CLKS_PER_BIT(1)) dut1 (
    .clk(clk), .rst(rst), .tx_data(tx_data), .tx_valid(tx_valid1),
    .tx_ready(tx_ready1), .busy(busy1), .uio_out(uio_out1), .uio_oe(uio_oe1)
  );

  function automatic logic [10:0] frame_bits(input logic [7:0] d);
    logic [10:0] b;
    b      = '1;
    b[0]   = 1'b0;
    b[8:1] = d;
`ifdef UIO_SERIAL_TX_PARITY_EN
    b[9]   = ^d;
`endif
    return b;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present a word and wait (bounded) for the accepting edge; returns #1 after it.
  task automatic accept(input logic [7:0] d, input bit hold);
    int w;
    w = 0;
    @(negedge clk);
    tx_data  = d;
    tx_valid = 1'b1;
    while (tx_ready !== 1'b1 && w < 200) begin
      @(negedge clk);
      w++;
    end
    chk("accept_ready", {31'b0, tx_ready}, 32'd1);
    exp_q.push_back(d);
    @(posedge clk);
    #1;
    if (!hold) tx_valid = 1'b0;
  endtask

  // Observe one frame starting the cycle after acceptance, plus the idle cycle after it.
  task automatic rx_frame(input string tag, output logic p9);
    logic [7:0]  exp_b, got;
    logic [10:0] bits;
    int bad, fcnt, rlow;
    bad = 0; fcnt = 0; rlow = 0; got = '0; p9 = 1'bx;
    exp_b = 8'h00;
    if (exp_q.size() > 0) exp_b = exp_q.pop_front();
    bits = frame_bits(exp_b);
    for (int i = 0; i < F; i++) begin
      @(negedge clk);
      if (uio_out[0] !== bits[i / C]) bad++;
      if (uio_out[7:2] !== 6'b0 || uio_oe !== 8'h03) bad++;
      if (uio_out[1] === 1'b1 && busy === 1'b1) fcnt++;
      if (tx_ready === 1'b0) rlow++;
      if ((i % C) == (C / 2) && (i / C) >= 1 && (i / C) <= 8) got[i / C - 1] = uio_out[0];
      if (i == 9 * C + C / 2) p9 = uio_out[0];
    end
    @(negedge clk);
    chk({tag, "_byte"}, {24'b0, got}, {24'b0, exp_b});
    chk({tag, "_line_bad_cycles"}, bad, 0);
    chk({tag, "_frame_len"}, fcnt, F);
    chk({tag, "_ready_low"}, rlow, F);
    chk({tag, "_end_frame"}, {31'b0, uio_out[1]}, 32'd0);
    chk({tag, "_end_ready"}, {31'b0, tx_ready}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        p9;
    logic [10:0] v1, e1;
    int          cnt;

    rst = 1'b1; tx_valid = 1'b0; tx_valid1 = 1'b0; tx_data = 8'h00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_uio_out", {24'b0, uio_out}, 32'h01);
    chk("rst_uio_oe", {24'b0, uio_oe}, 32'h03);
    chk("rst_ready", {31'b0, tx_ready}, 32'd1);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    rst = 1'b0;

    // Single word
    accept(8'hA5, 1'b0);
    rx_frame("a5", p9);
`ifdef UIO_SERIAL_TX_PARITY_EN
    chk("a5_parity", {31'b0, p9}, 32'd0);
`else
    chk("a5_stop", {31'b0, p9}, 32'd1);
`endif

    // Parity (odd number of ones -> parity 1; stop is 1 without parity)
    accept(8'h07, 1'b0);
    rx_frame("p07", p9);
    chk("p07_bit9", {31'b0, p9}, 32'd1);

    // Back-to-back with tx_valid held high
    accept(8'h00, 1'b1);
    fork
      rx_frame("b2b0", p9);
      begin
        @(negedge clk);
        tx_data = 8'hFF;
      end
    join
    exp_q.push_back(8'hFF);
    @(posedge clk);
    #1;
    tx_valid = 1'b0;
    rx_frame("b2b1", p9);

    // Ignored input mid-frame
    accept(8'hC3, 1'b0);
    fork
      rx_frame("ign", p9);
      begin
        repeat (12) @(negedge clk);
        tx_data  = 8'h3C;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        tx_data  = 8'h55;
      end
    join
    cnt = 0;
    for (int i = 0; i < 3 * F; i++) begin
      @(negedge clk);
      if (uio_out[1] !== 1'b0) cnt++;
    end
    chk("ign_no_extra_frame", cnt, 0);

    // Reset during data bit 3
    accept(8'h5A, 1'b0);
    void'(exp_q.pop_back());
    repeat (4 * C + 1) @(negedge clk);
    chk("midrst_pre_busy", {31'b0, busy}, 32'd1);
    chk("midrst_pre_line", {31'b0, uio_out[0]}, 32'd1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("midrst_uio_out", {24'b0, uio_out}, 32'h01);
    chk("midrst_ready", {31'b0, tx_ready}, 32'd1);
    chk("midrst_busy", {31'b0, busy}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    accept(8'h96, 1'b0);
    rx_frame("postrst", p9);

    // One clock per bit
    @(negedge clk);
    tx_data   = 8'hA5;
    tx_valid1 = 1'b1;
    @(posedge clk);
    #1;
    tx_valid1 = 1'b0;
    v1  = '1;
    cnt = 0;
    for (int i = 0; i < NB; i++) begin
      @(negedge clk);
      v1[i] = uio_out1[0];
      if (uio_out1[1] === 1'b1) cnt++;
    end
    e1 = frame_bits(8'hA5);
    chk("cpb1_bits", {21'b0, v1}, {21'b0, e1});
    chk("cpb1_frame_len", cnt, NB);
    @(negedge clk);
    chk("cpb1_end_ready", {31'b0, tx_ready1}, 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
